// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output register
// Start is validated at half a bit; data and stop are sampled a full bit apart from there.
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_TICKS = CLOCK_FREQ / BAUD;
  localparam int HALF_TICKS = BAUD_TICKS / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_meta_q, rx_s_q;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
            // A consumer taking the old byte this cycle frees the slot for the new one.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and random frames against uart_rx with a timing/byte reference model
module tb_uart_rx;

  localparam int CF  = 4100;
  localparam int BR  = 100;
  localparam int B   = CF / BR;
  localparam int H   = B / 2;
  localparam int LAT = 2 + H + 9 * B + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_fall = 0;

  int valid_rises = 0;
  int ferr_cnt    = 0;
  int ovr_cnt     = 0;
  int viol        = 0;
  int busy_cycles = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLOCK_FREQ(CF), .BAUD(BR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx_line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: pulse counts, pulse-width/exclusivity violations, accepted bytes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && !prev_valid) valid_rises++;
      if (frame_err && !prev_ferr) ferr_cnt++;
      if (overrun && !prev_ovr) ovr_cnt++;
      if ((frame_err && prev_ferr) || (overrun && prev_ovr) || (frame_err && overrun)) viol++;
      if (busy) busy_cycles++;
      if (rx_valid && rx_ready) cap.push_back(rx_data);
    end
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_line   = 1'b0;
    last_fall = cyc;
    wait_n(B);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      wait_n(B);
    end
    rx_line = stop;
    wait_n(B);
  endtask

  initial begin
    int base, r0, f0, o0, v0, gap;
    logic [7:0] rb;
    logic [7:0] c3;

    rx_line  = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    wait_n(3);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 0);
    check("reset_ferr", {31'd0, frame_err}, 0);
    check("reset_ovr", {31'd0, overrun}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    wait_n(3);

    // Loopback-style exact latency check, consumer not ready.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_n(LAT - 1);
        check("lat_valid_early", {31'd0, rx_valid}, 0);
        check("lat_busy_before", {31'd0, busy}, 1);
        wait_n(1);
        check("lat_valid", {31'd0, rx_valid}, 1);
        check("lat_data", {24'd0, rx_data}, 32'hA5);
        check("lat_busy_after", {31'd0, busy}, 0);
      end
    join
    wait_n(2);

    // Back-to-back frames with the consumer always ready.
    rx_ready = 1'b1;
    wait_n(2);
    base = cap.size(); r0 = valid_rises; f0 = ferr_cnt; o0 = ovr_cnt;
    begin
      int vc0;
      vc0 = valid_rises;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      wait_n(2 * B);
      check("b2b_count", cap.size() - base, 3);
      check("b2b_rises", valid_rises - vc0, 3);
    end
    if (cap.size() - base == 3) begin
      check("b2b_0", {24'd0, cap[base]}, 32'h00);
      check("b2b_1", {24'd0, cap[base+1]}, 32'hFF);
      check("b2b_2", {24'd0, cap[base+2]}, 32'h55);
    end
    check("b2b_ferr", ferr_cnt - f0, 0);
    check("b2b_ovr", ovr_cnt - o0, 0);
    check("b2b_valid_low", {31'd0, rx_valid}, 0);

    // Glitch shorter than half a bit.
    r0 = valid_rises; f0 = ferr_cnt; v0 = busy_cycles;
    rx_line = 1'b0;
    wait_n(6);
    rx_line = 1'b1;
    wait_n(3 * B);
    check("glitch_busy_cycles", busy_cycles - v0, H);
    check("glitch_no_valid", valid_rises - r0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Framing error followed by a break, then a good frame.
    r0 = valid_rises; f0 = ferr_cnt; base = cap.size();
    send_frame(8'h3C, 1'b0);
    wait_n(5 * B);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_rises - r0, 0);
    check("ferr_busy_in_break", {31'd0, busy}, 1);
    rx_line = 1'b1;
    wait_n(5);
    check("ferr_busy_released", {31'd0, busy}, 0);
    send_frame(8'h3C, 1'b1);
    wait_n(B);
    check("ferr_recover_count", cap.size() - base, 1);
    if (cap.size() - base == 1) check("ferr_recover_data", {24'd0, cap[base]}, 32'h3C);

    // Overrun: second byte arrives with the first still held.
    rx_ready = 1'b0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_n(B);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    check("ovr_valid", {31'd0, rx_valid}, 1);
    check("ovr_pulse", ovr_cnt - o0, 1);

    // Consumer accepts in the exact delivery cycle: new byte replaces old, no overrun.
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_n(LAT - 1);
        rx_ready = 1'b1;
        wait_n(1);
        rx_ready = 1'b0;
        check("sim_valid_kept", {31'd0, rx_valid}, 1);
      end
    join
    check("sim_data", {24'd0, rx_data}, 32'h22);
    check("sim_valid", {31'd0, rx_valid}, 1);
    check("sim_no_ovr", ovr_cnt - o0, 0);
    check("sim_no_ferr", ferr_cnt - f0, 0);

    // Reset asserted during data bit 4 of 0xC3.
    c3 = 8'hC3;
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_line = 1'b0;
    wait_n(B);
    for (int i = 0; i < 4; i++) begin
      rx_line = c3[i];
      wait_n(B);
    end
    rx_line = c3[4];
    wait_n(H);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", {24'd0, rx_data}, 32'h00);
    check("rst_mid_valid", {31'd0, rx_valid}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_ferr", {31'd0, frame_err}, 0);
    check("rst_mid_ovr", {31'd0, overrun}, 0);
    rx_line = 1'b1;
    wait_n(3);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_n(3);
    base = cap.size();
    send_frame(8'h5A, 1'b1);
    wait_n(B);
    check("rst_recover_count", cap.size() - base, 1);
    if (cap.size() - base == 1) check("rst_recover_data", {24'd0, cap[base]}, 32'h5A);
    check("rst_no_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

    // Random bytes with random inter-frame gaps, checked against the sent-byte queue.
    base = cap.size();
    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, B);
      exp_q.push_back(rb);
      send_frame(rb, 1'b1);
      wait_n(gap);
    end
    wait_n(2 * B);
    check("rand_count", cap.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < cap.size()) check("rand_byte", {24'd0, cap[base+k]}, {24'd0, exp_q[k]});
    end

    check("pulse_width_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
